// File: rtl/dac_ctrl_pkg.sv
// dac_ctrl_pkg: shared FSM encoding and round-robin channel picker for the DAC setpoint controller
package dac_ctrl_pkg;
    localparam int MAX_CH = 8;
    localparam int MAX_CW = 3;
    typedef enum logic {ST_IDLE, ST_REQ} dac_state_t;
    // First requesting channel strictly after 'last', wrapping at n; 'last' itself is checked last.
    function automatic logic [MAX_CW-1:0] rr_pick(input logic [MAX_CH-1:0] req, input logic [MAX_CW-1:0] last, input int n);
        rr_pick = last;
        for (int k = n; k >= 1; k--)
            if (req[(int'(last) + k) % n]) rr_pick = MAX_CW'((int'(last) + k) % n);
    endfunction
endpackage

// File: rtl/debounce.sv
// debounce: per-bit synchroniser plus stability counter; level follows raw after DEBOUNCE steady cycles
module debounce #(
    parameter int DEBOUNCE = 16,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] level
);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    logic [W-1:0] s0, s1;
    logic [W-1:0][CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= '0;
            s1 <= '0;
            level <= '0;
            cnt <= '0;
        end else begin
            s0 <= raw;
            s1 <= s0;
            for (int i = 0; i < W; i++) begin
                if (s1[i] == level[i]) cnt[i] <= '0;
                else if (cnt[i] == CNT_W'(DEBOUNCE - 1)) begin
                    level[i] <= s1[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
endmodule

// File: rtl/dac_setpoint_ctrl.sv
// dac_setpoint_ctrl: button/switch-driven per-channel setpoints with round-robin update requests to a DAC driver
module dac_setpoint_ctrl
    import dac_ctrl_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH = 12,
    parameter int SW_W = 4,
    parameter int STEP = 256,
    parameter int DEBOUNCE = 16,
    parameter int INIT = 0,
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                      CLK50MHZ,
    input  logic                      RST,
    input  logic                      BTN_WEST,
    input  logic                      BTN_EAST,
    input  logic [SW_W-1:0]           SW,
    input  logic [CW-1:0]             CH_SEL,
    output logic [CHANNELS*WIDTH-1:0] VALUE,
    output logic                      DAC_REQ,
    output logic [CW-1:0]             DAC_CH,
    output logic [WIDTH-1:0]          DAC_DATA,
    input  logic                      DAC_ACK
);
    localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);
    dac_state_t state;
    logic [CHANNELS-1:0][WIDTH-1:0] val;
    logic [CHANNELS-1:0] dirty, set_m, clr_m;
    logic [CW-1:0] last, pick;
    logic [1:0] btn_db, btn_prev;
    logic [SW_W-1:0] sw_db, sw_prev;
    logic inc, dec, load;
    logic [WIDTH-1:0] cur, nxt;
    logic [WIDTH:0] sum;

    debounce #(.DEBOUNCE(DEBOUNCE), .W(2)) u_btn_db (
        .clk(CLK50MHZ), .rst(RST), .raw({BTN_EAST, BTN_WEST}), .level(btn_db)
    );
    debounce #(.DEBOUNCE(DEBOUNCE), .W(SW_W)) u_sw_db (
        .clk(CLK50MHZ), .rst(RST), .raw(SW), .level(sw_db)
    );

    // Load beats buttons; opposing button events cancel; arithmetic saturates both ways.
    always_comb begin
        inc = btn_db[0] & ~btn_prev[0];
        dec = btn_db[1] & ~btn_prev[1];
        load = sw_db != sw_prev;
        cur = val[CH_SEL];
        sum = {1'b0, cur} + STEP_W;
        nxt = load ? WIDTH'(sw_db) << (WIDTH - SW_W)
            : (inc && !dec) ? (sum[WIDTH] ? '1 : sum[WIDTH-1:0])
            : (dec && !inc) ? ({1'b0, cur} < STEP_W ? '0 : cur - STEP_W[WIDTH-1:0])
            : cur;
        pick = CW'(rr_pick(MAX_CH'(dirty), MAX_CW'(last), CHANNELS));
        set_m = nxt != cur ? CHANNELS'(1) << CH_SEL : '0;
        clr_m = (state == ST_IDLE && |dirty) ? CHANNELS'(1) << pick : '0;
    end

    assign VALUE = val;

    // A same-cycle change to the channel being latched keeps it dirty, giving a follow-up request.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            val <= {CHANNELS{WIDTH'(INIT)}};
            dirty <= '1;
            last <= CW'(CHANNELS - 1);
            state <= ST_IDLE;
            DAC_REQ <= 1'b0;
            DAC_CH <= '0;
            DAC_DATA <= '0;
            btn_prev <= '0;
            sw_prev <= '0;
        end else begin
            btn_prev <= btn_db;
            sw_prev <= sw_db;
            val[CH_SEL] <= nxt;
            dirty <= (dirty & ~clr_m) | set_m;
            if (state == ST_IDLE) begin
                if (|dirty) begin
                    state <= ST_REQ;
                    DAC_REQ <= 1'b1;
                    DAC_CH <= pick;
                    DAC_DATA <= val[pick];
                    last <= pick;
                end
            end else if (DAC_ACK) begin
                state <= ST_IDLE;
                DAC_REQ <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dac_setpoint_ctrl.sv
// tb_dac_setpoint_ctrl: randomized scenario bench with a saturating-arithmetic setpoint model and request log
module tb_dac_setpoint_ctrl;
    logic clk = 0, rst = 1, btn_west = 0, btn_east = 0, dac_ack, dac_req;
    logic [3:0] sw = 0;
    logic [1:0] ch_sel = 0, dac_ch;
    logic [47:0] value;
    logic [11:0] dac_data;

    typedef struct {int ch; int data;} req_t;
    req_t got_q[$], exp_q[$];
    int mval[4];
    int checks = 0, errors = 0;
    int ack_tokens = 0, ack_done = 0, wait_cnt = 0;
    bit auto_ack = 1, prev_req = 0;

    dac_setpoint_ctrl dut (
        .CLK50MHZ(clk), .RST(rst), .BTN_WEST(btn_west), .BTN_EAST(btn_east), .SW(sw),
        .CH_SEL(ch_sel), .VALUE(value), .DAC_REQ(dac_req), .DAC_CH(dac_ch),
        .DAC_DATA(dac_data), .DAC_ACK(dac_ack)
    );

    always #10 clk = ~clk;

    // Log every request as it rises.
    initial forever begin
        @(negedge clk);
        if (dac_req && !prev_req) got_q.push_back('{int'(dac_ch), int'(dac_data)});
        prev_req = dac_req;
    end

    // Driver model: acks three cycles after a request when auto_ack, or on demand via ack_tokens.
    initial begin
        dac_ack = 0;
        forever begin
            @(negedge clk);
            if (dac_ack) dac_ack = 0;
            else if (ack_done < ack_tokens) begin
                dac_ack = 1;
                ack_done++;
            end else if (auto_ack && dac_req) begin
                if (wait_cnt == 2) begin
                    dac_ack = 1;
                    wait_cnt = 0;
                end else wait_cnt++;
            end else wait_cnt = 0;
        end
    end

    function automatic int sat_inc(int v); return v + 256 > 4095 ? 4095 : v + 256; endfunction
    function automatic int sat_dec(int v); return v < 256 ? 0 : v - 256; endfunction

    task automatic model_set(input int c, input int nv);
        if (nv != mval[c]) begin
            mval[c] = nv;
            exp_q.push_back('{c, nv});
        end
    endtask

    task automatic press(input bit east, input int hold);
        if (east) btn_east = 1; else btn_west = 1;
        repeat (hold) @(negedge clk);
        btn_east = 0;
        btn_west = 0;
        repeat (40) @(negedge clk);
    endtask

    task automatic set_sw(input logic [3:0] v, input int hold);
        sw = v;
        repeat (hold) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int quiet = 0, n = 0;
        while (quiet < 12 && n < 600) begin
            @(negedge clk);
            n++;
            quiet = dac_req ? 0 : quiet + 1;
        end
        checks++;
        if (quiet < 12) begin
            errors++;
            $display("FAIL %s drain_timeout req still %b after %0d cycles", name, dac_req, n);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (value !== 48'h0 || dac_req !== 1'b0 || dac_ch !== 2'd0 || dac_data !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs got value=%h req=%b ch=%0d data=%h want all zero", value, dac_req, dac_ch, dac_data);
        end
        got_q.delete();
        exp_q.delete();
        for (int c = 0; c < 4; c++) begin
            mval[c] = 0;
            exp_q.push_back('{c, 0});
        end
        rst = 0;
        drain("reset");
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_req_count got %0d want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i].ch != exp_q[i].ch || got_q[i].data != exp_q[i].data) begin
                errors++;
                $display("FAIL reset_req%0d got ch%0d/%h want ch%0d/%h", i, got_q[i].ch, got_q[i].data, exp_q[i].ch, exp_q[i].data);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_inc;
        ch_sel = 1;
        for (int p = 0; p < 2; p++) begin
            press(0, 250);
            model_set(1, sat_inc(mval[1]));
            drain("inc");
            checks++;
            if (value[12 +: 12] !== 12'(mval[1])) begin
                errors++;
                $display("FAIL inc_value press%0d got %h want %h", p, value[12 +: 12], mval[1]);
            end
            checks++;
            if (got_q.size() != 1 || got_q[0].ch != 1 || got_q[0].data != mval[1]) begin
                errors++;
                $display("FAIL inc_req press%0d got %0d reqs want one ch1/%h", p, got_q.size(), mval[1]);
            end
            got_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_bounce;
        ch_sel = 1;
        repeat (12) begin
            btn_east = 1;
            repeat (10) @(negedge clk);
            btn_east = 0;
            repeat (10) @(negedge clk);
        end
        drain("bounce");
        checks++;
        if (value[12 +: 12] !== 12'(mval[1]) || got_q.size() != 0) begin
            errors++;
            $display("FAIL bounce got value=%h reqs=%0d want %h and 0", value[12 +: 12], got_q.size(), mval[1]);
        end
        got_q.delete();
    endtask

    task automatic test_saturation;
        ch_sel = 0;
        set_sw(4'hF, 40);
        model_set(0, 'hF00);
        press(0, 30);
        model_set(0, sat_inc(mval[0]));
        press(0, 30);
        model_set(0, sat_inc(mval[0]));
        checks++;
        if (value[11:0] !== 12'hFFF) begin
            errors++;
            $display("FAIL sat_high got %h want fff", value[11:0]);
        end
        ch_sel = 3;
        press(1, 30);
        model_set(3, sat_dec(mval[3]));
        ch_sel = 0;
        set_sw(4'h0, 40);
        model_set(0, 0);
        drain("sat");
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (value[c*12 +: 12] !== 12'(mval[c])) begin
                errors++;
                $display("FAIL sat_value ch%0d got %h want %h", c, value[c*12 +: 12], mval[c]);
            end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sat_req_count got %0d want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i].ch != exp_q[i].ch || got_q[i].data != exp_q[i].data) begin
                errors++;
                $display("FAIL sat_req%0d got ch%0d/%h want ch%0d/%h", i, got_q[i].ch, got_q[i].data, exp_q[i].ch, exp_q[i].data);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_load;
        ch_sel = 2;
        set_sw(4'h1, 2000);
        model_set(2, 'h100);
        checks++;
        if (value[24 +: 12] !== 12'h100) begin
            errors++;
            $display("FAIL load_value got %h want 100", value[24 +: 12]);
        end
        set_sw(4'h0, 40);
        model_set(2, 0);
        drain("load");
        checks++;
        if (value[24 +: 12] !== 12'h000) begin
            errors++;
            $display("FAIL load_restore got %h want 000", value[24 +: 12]);
        end
        checks++;
        if (got_q.size() != 2 || got_q[0].data != 'h100 || got_q[1].data != 0 || got_q[0].ch != 2 || got_q[1].ch != 2) begin
            errors++;
            $display("FAIL load_reqs got %0d reqs want ch2/100 then ch2/000", got_q.size());
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_coincident;
        ch_sel = 1;
        btn_west = 1;
        btn_east = 1;
        repeat (30) @(negedge clk);
        btn_west = 0;
        btn_east = 0;
        repeat (40) @(negedge clk);
        sw = 4'h5;
        press(0, 30);
        model_set(1, 'h500);
        drain("coincident");
        checks++;
        if (value[12 +: 12] !== 12'(mval[1])) begin
            errors++;
            $display("FAIL coincident_value got %h want %h", value[12 +: 12], mval[1]);
        end
        checks++;
        if (got_q.size() != 1 || got_q[0].ch != 1 || got_q[0].data != mval[1]) begin
            errors++;
            $display("FAIL coincident_req got %0d reqs want one ch1/%h", got_q.size(), mval[1]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random;
        for (int it = 0; it < 24; it++) begin
            int c = $urandom_range(0, 3);
            int op = $urandom_range(0, 3);
            ch_sel = 2'(c);
            repeat (3) @(negedge clk);
            if (op == 0) begin
                press(0, $urandom_range(25, 60));
                model_set(c, sat_inc(mval[c]));
            end else if (op == 1) begin
                press(1, $urandom_range(25, 60));
                model_set(c, sat_dec(mval[c]));
            end else if (op == 2) begin
                logic [3:0] nv = 4'($urandom_range(0, 15));
                if (nv != sw) model_set(c, int'(nv) * 256);
                set_sw(nv, 40);
            end else begin
                btn_west = 1;
                btn_east = 1;
                repeat ($urandom_range(25, 60)) @(negedge clk);
                btn_west = 0;
                btn_east = 0;
                repeat (40) @(negedge clk);
            end
            drain("random");
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (value[k*12 +: 12] !== 12'(mval[k])) begin
                    errors++;
                    $display("FAIL random_value it%0d ch%0d got %h want %h", it, k, value[k*12 +: 12], mval[k]);
                end
            end
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL random_req_count it%0d got %0d want %0d", it, got_q.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                checks++;
                if (got_q[i].ch != exp_q[i].ch || got_q[i].data != exp_q[i].data) begin
                    errors++;
                    $display("FAIL random_req it%0d got ch%0d/%h want ch%0d/%h", it, got_q[i].ch, got_q[i].data, exp_q[i].ch, exp_q[i].data);
                end
            end
            got_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_withheld;
        int n = 0;
        sw = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        for (int c = 0; c < 4; c++) mval[c] = 0;
        drain("withheld_reset");
        got_q.delete();
        auto_ack = 0;
        ch_sel = 3;
        press(0, 30);
        checks++;
        if (dac_req !== 1'b1 || dac_ch !== 2'd3 || dac_data !== 12'h100) begin
            errors++;
            $display("FAIL withheld_first got req=%b ch=%0d data=%h want 1/3/100", dac_req, dac_ch, dac_data);
        end
        press(0, 30);
        checks++;
        if (dac_req !== 1'b1 || dac_data !== 12'h100 || value[36 +: 12] !== 12'h200) begin
            errors++;
            $display("FAIL withheld_hold got req=%b data=%h value=%h want 1/100/200", dac_req, dac_data, value[36 +: 12]);
        end
        ack_tokens++;
        while (got_q.size() < 2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("FAIL withheld_followup got %0d reqs want 2", got_q.size());
        end else if (got_q[1].ch != 3 || got_q[1].data != 'h200 || n > 4) begin
            errors++;
            $display("FAIL withheld_followup got ch%0d/%h after %0d cycles want ch3/200 within 4", got_q[1].ch, got_q[1].data, n);
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if (dac_req !== 1'b0 || value !== 48'h0) begin
            errors++;
            $display("FAIL reset_mid_req got req=%b value=%h want 0/0", dac_req, value);
        end
        rst = 0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_inc;
        test_bounce;
        test_saturation;
        test_load;
        test_coincident;
        test_random;
        test_withheld;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dac_setpoint_ctrl.md
DAC_SETPOINT_CTRL -- requirements
Module: dac_setpoint_ctrl

Interface
REQ-001 Parameter CHANNELS, default 4, SHALL set the number of DAC channels (power of two, 1..8).
REQ-002 Parameter WIDTH, default 12, SHALL set the setpoint width per channel.
REQ-003 Parameter SW_W, default 4, SHALL set the switch width (SW_W <= WIDTH).
REQ-004 Parameter STEP, default 256, SHALL set the button increment/decrement amount.
REQ-005 Parameter DEBOUNCE, default 16, SHALL set the clock cycles an input must be stable to be accepted.
REQ-006 Parameter INIT, default 0, SHALL set the reset setpoint of every channel.
REQ-007 The block SHALL use one clock, CLK50MHZ, and a synchronous active-high reset, RST.
REQ-008 CLK50MHZ  in  1  system clock.
REQ-009 RST  in  1  synchronous active-high reset.
REQ-010 BTN_WEST  in  1  raw increment button.
REQ-011 BTN_EAST  in  1  raw decrement button.
REQ-012 SW  in  SW_W  raw preset switches.
REQ-013 CH_SEL  in  log2(CHANNELS) (min 1)  channel targeted by buttons/switches.
REQ-014 VALUE  out  CHANNELS*WIDTH  flattened setpoints, channel 0 in LSBs.
REQ-015 DAC_REQ  out  1  update request to the downstream SPI DAC driver.
REQ-016 DAC_CH  out  log2(CHANNELS)  channel of the pending request.
REQ-017 DAC_DATA  out  WIDTH  value of the pending request.
REQ-018 DAC_ACK  in  1  one-cycle acknowledge from the driver.

Function
REQ-019 Each raw input bit SHALL be debounced: the debounced level updates only after the raw level has differed from it for DEBOUNCE consecutive cycles; any shorter glitch resets the counter.
REQ-020 A debounced rising edge of BTN_WEST/BTN_EAST SHALL generate a one-cycle inc/dec event; falling edges generate nothing.
REQ-021 Any change of the debounced SW word SHALL generate a load event with value {SW, (WIDTH-SW_W) zeros}.
REQ-022 An event SHALL update VALUE[CH_SEL] on the clock edge after the event cycle (1-cycle latency).
REQ-023 Inc SHALL saturate at 2^WIDTH-1 and dec SHALL saturate at 0, with no wrap-around.
REQ-024 Simultaneous inc and dec in the same cycle SHALL both be ignored.
REQ-025 Load coinciding with inc or dec SHALL take priority, and the button event SHALL be dropped.
REQ-026 An event that changes a channel's value SHALL set that channel's dirty bit; an event leaving the value unchanged (saturated, or an identical load) SHALL NOT.
REQ-027 FSM IDLE: when any dirty bit is set, SHALL select the first dirty channel in round-robin order after the last channel served, latch DAC_CH/DAC_DATA, clear that dirty bit, and go to REQ.
REQ-028 FSM REQ: DAC_REQ=1 and DAC_CH/DAC_DATA SHALL be held stable; on DAC_ACK, DAC_REQ SHALL drop next edge and the FSM returns to IDLE.
REQ-029 From a set dirty bit with the FSM in IDLE, DAC_REQ SHALL rise within 2 cycles.
REQ-030 Events during REQ SHALL update VALUE and set dirty bits immediately; a further change to the channel in flight re-dirties it, so a follow-up request carries the newest value (coalescing, no queue).
REQ-031 DAC_ACK while in IDLE SHALL be ignored.

Reset
REQ-032 While RST is high: VALUE=INIT on all channels, DAC_REQ=0, DAC_CH=0, DAC_DATA=0, FSM=IDLE, round-robin pointer = CHANNELS-1, debounced levels = 0, counters = 0.
REQ-033 Reset SHALL set all dirty bits so every channel is written after reset; a reset mid-REQ abandons the transaction with no DAC_ACK required.

Structure
REQ-034 FSM state encodings and the round-robin helper constants SHALL live in the shared package dac_ctrl_pkg.
REQ-035 Debouncing SHALL be the sub-module debounce (params DEBOUNCE and width), instantiated once for the buttons and once for SW.

Verification (CHANNELS=4, WIDTH=12, SW_W=4, STEP=256, DEBOUNCE=16, INIT=0)
REQ-036 Release of RST with DAC_ACK returned 3 cycles after each request -> four requests, ch0..ch3 in order, each with DAC_DATA=0x000.
REQ-037 CH_SEL=1, BTN_WEST high for 250 cycles -> VALUE[1]=0x100 and exactly one request (ch1, 0x100); a second press -> 0x200.
REQ-038 Bounce: BTN_EAST pulses of 10 cycles high / 10 low repeated -> no event, VALUE unchanged, no request.
REQ-039 Saturation: VALUE[0]=0xF00 and BTN_WEST pressed twice -> 0xFFF then still 0xFFF with no second request; BTN_EAST at 0x000 -> stays 0x000 with no request.
REQ-040 CH_SEL=2, SW=4'h1 held 2000 cycles then restored to 0 -> VALUE[2]=0x100 then 0x000, giving two requests in order.
REQ-041 DAC_ACK withheld and two BTN_WEST presses on ch3 during REQ -> DAC_DATA stays at the first value; after ack, a follow-up request carries 0x200; RST asserted mid-REQ -> DAC_REQ=0 on the next edge.
